// File: rtl/contador_param.sv
// contador_param: parametrised up/down/step counter with parallel load.
// Per-slice ripple-carry/borrow flags and a sticky overflow flag are
// registered alongside Q. SAT selects wrap-around or clamping at the bounds.
// WIDTH must be a multiple of SLICE, and STEP must lie in 1..2^SLICE-1.
module contador_param #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4,
  parameter int STEP  = 3,
  parameter int SAT   = 0,
  localparam int NS   = WIDTH / SLICE
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enb,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [NS-1:0]    RCO,
  output logic             ovf
);

  localparam logic [WIDTH:0] ONE_W  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

  logic [WIDTH:0]   operand;
  logic             do_arith;
  logic             is_up;
  logic             is_load;
  logic [WIDTH:0]   result;
  logic             full_cy;
  logic [NS-1:0]    slice_cy;
  logic [WIDTH-1:0] q_next;
  logic [NS-1:0]    rco_next;
  logic             ovf_next;

  // Decode enable and mode into an operation; unknown modes fall to hold.
  always_comb begin
    operand  = '0;
    do_arith = 1'b0;
    is_up    = 1'b0;
    is_load  = 1'b0;
    if (enb) begin
      case (modo)
        2'b00: begin
          do_arith = 1'b1;
          is_up    = 1'b1;
          operand  = ONE_W;
        end
        2'b01: begin
          do_arith = 1'b1;
          operand  = ONE_W;
        end
        2'b10: begin
          do_arith = 1'b1;
          operand  = STEP_W;
        end
        2'b11: begin
          is_load = 1'b1;
        end
        default: begin
          do_arith = 1'b0;
        end
      endcase
    end
  end

  // Full-width add/subtract one bit wider than Q; the top bit is the carry or borrow.
  always_comb begin
    result  = is_up ? ({1'b0, Q} + operand) : ({1'b0, Q} - operand);
    full_cy = result[WIDTH];
  end

  // Carry/borrow out of each prefix Q[(i+1)*SLICE-1:0]: redo the operation on
  // the masked prefix; a borrow leaves the bit above the prefix set.
  always_comb begin
    logic [WIDTH:0] mask;
    logic [WIDTH:0] part;
    slice_cy = '0;
    for (int i = 0; i < NS; i++) begin
      mask = (ONE_W << ((i + 1) * SLICE)) - ONE_W;
      part = is_up ? (({1'b0, Q} & mask) + operand) : (({1'b0, Q} & mask) - operand);
      slice_cy[i] = part[(i + 1) * SLICE];
    end
  end

  // Next-state selection: load, wrap or clamp on overflow, else hold.
  always_comb begin
    q_next   = Q;
    rco_next = '0;
    ovf_next = ovf;
    if (is_load) begin
      q_next   = D;
      ovf_next = 1'b0;
    end else if (do_arith) begin
      if (full_cy) begin
        ovf_next = 1'b1;
        if (SAT != 0) begin
          q_next   = is_up ? '1 : '0;
          rco_next = '0;
        end else begin
          q_next   = result[WIDTH-1:0];
          rco_next = slice_cy;
        end
      end else begin
        q_next   = result[WIDTH-1:0];
        rco_next = slice_cy;
      end
    end
  end

  // Output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      Q   <= '0;
      RCO <= '0;
      ovf <= 1'b0;
    end else begin
      Q   <= q_next;
      RCO <= rco_next;
      ovf <= ovf_next;
    end
  end

endmodule

// File: tb/tb_contador_param.sv
// Bench for contador_param: one wrapping and one saturating instance share
// the same stimulus; an arithmetic reference model predicts both.
module tb_contador_param;

  localparam int W  = 16;
  localparam int NS = 4;
  localparam int ST = 3;

  typedef struct packed {
    logic [W-1:0]  q0;
    logic [NS-1:0] r0;
    logic          o0;
    logic [W-1:0]  q1;
    logic [NS-1:0] r1;
    logic          o1;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic          clk;
  logic          reset_L;
  logic          enb;
  logic [1:0]    modo;
  logic [W-1:0]  D;
  logic [W-1:0]  q_w, q_s;
  logic [NS-1:0] rco_w, rco_s;
  logic          ovf_w, ovf_s;

  logic [EW-1:0] exp_q[$];
  int tests;
  int fails;

  // Reference model state: value and sticky flag for each instance.
  int m_q0, m_q1;
  bit m_o0, m_o1;

  contador_param #(.WIDTH(W), .SLICE(4), .STEP(ST), .SAT(0)) dut_wrap (
    .clk(clk), .reset_L(reset_L), .enb(enb), .modo(modo), .D(D),
    .Q(q_w), .RCO(rco_w), .ovf(ovf_w)
  );

  contador_param #(.WIDTH(W), .SLICE(4), .STEP(ST), .SAT(1)) dut_sat (
    .clk(clk), .reset_L(reset_L), .enb(enb), .modo(modo), .D(D),
    .Q(q_s), .RCO(rco_s), .ovf(ovf_s)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural model from the counting rules, using plain integer arithmetic.
  function automatic void model(input int q, input bit ov, input bit sat, input bit e,
                                input bit [1:0] m, input int d,
                                output int nq, output bit [3:0] rco, output bit nov);
    int op, v, md;
    bit up;
    nq = q; rco = 4'b0000; nov = ov;
    if (!e) return;
    if (m == 2'b11) begin
      nq = d; nov = 1'b0;
      return;
    end
    up = (m == 2'b00);
    op = (m == 2'b10) ? ST : 1;
    for (int i = 0; i < NS; i++) begin
      md = 1 << (4 * (i + 1));
      rco[i] = up ? ((q % md) + op >= md) : ((q % md) < op);
    end
    v = up ? q + op : q - op;
    if (v >= 0 && v < 65536) begin
      nq = v;
    end else begin
      nov = 1'b1;
      if (sat) begin
        nq = up ? 65535 : 0;
        rco = 4'b0000;
      end else begin
        nq = up ? v - 65536 : v + 65536;
      end
    end
  endfunction

  // Driver: apply one operation at the falling edge and queue the prediction.
  task automatic step(input bit e, input bit [1:0] m, input int d);
    exp_t x;
    int nq;
    bit [3:0] r;
    bit no;
    @(negedge clk);
    reset_L = 1'b1;
    enb = e; modo = m; D = W'(d);
    model(m_q0, m_o0, 1'b0, e, m, d, nq, r, no);
    m_q0 = nq; m_o0 = no;
    x.q0 = W'(nq); x.r0 = r; x.o0 = no;
    model(m_q1, m_o1, 1'b1, e, m, d, nq, r, no);
    m_q1 = nq; m_o1 = no;
    x.q1 = W'(nq); x.r1 = r; x.o1 = no;
    exp_q.push_back(x);
  endtask

  // Monitor: every rising edge carries one result; compare just after it.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("q_wrap",   32'(q_w),   32'(x.q0));
      chk("rco_wrap", 32'(rco_w), 32'(x.r0));
      chk("ovf_wrap", 32'(ovf_w), 32'(x.o0));
      chk("q_sat",    32'(q_s),   32'(x.q1));
      chk("rco_sat",  32'(rco_s), 32'(x.r1));
      chk("ovf_sat",  32'(ovf_s), 32'(x.o1));
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_q_wrap"},   32'(q_w),   32'h0);
    chk({tag, "_rco_wrap"}, 32'(rco_w), 32'h0);
    chk({tag, "_ovf_wrap"}, 32'(ovf_w), 32'h0);
    chk({tag, "_q_sat"},    32'(q_s),   32'h0);
    chk({tag, "_rco_sat"},  32'(rco_s), 32'h0);
    chk({tag, "_ovf_sat"},  32'(ovf_s), 32'h0);
  endtask

  initial begin
    int dsel, dv;
    tests = 0; fails = 0;
    m_q0 = 0; m_q1 = 0; m_o0 = 1'b0; m_o1 = 1'b0;
    reset_L = 1'b0; enb = 1'b0; modo = 2'b00; D = '0;
    #2;
    check_reset("por");
    @(posedge clk);

    // Reset mid-count: load 0x0010, count, drop reset between edges.
    step(1, 2'b11, 16'h0010);
    step(1, 2'b00, 0);
    step(1, 2'b00, 0);
    @(posedge clk);
    #3;
    reset_L = 1'b0;
    #1;
    check_reset("async");
    m_q0 = 0; m_q1 = 0; m_o0 = 1'b0; m_o1 = 1'b0;
    @(posedge clk);
    step(1, 2'b00, 0);

    // Slice carry from 0x00FF, then a plain count.
    step(1, 2'b11, 16'h00FF);
    step(1, 2'b00, 0);
    step(1, 2'b00, 0);

    // Full-width carry and sticky overflow until a load.
    step(1, 2'b11, 16'hFFFF);
    step(1, 2'b00, 0);
    step(1, 2'b00, 0);
    step(1, 2'b01, 0);
    step(1, 2'b11, 16'h1234);

    // Step-down borrow through zero, then decrement.
    step(1, 2'b11, 16'h0002);
    step(1, 2'b10, 0);
    step(1, 2'b01, 0);

    // Bounds for the saturating instance.
    step(1, 2'b11, 16'h0001);
    step(1, 2'b10, 0);
    step(1, 2'b10, 0);
    step(1, 2'b11, 16'hFFFE);
    step(1, 2'b00, 0);
    step(1, 2'b00, 0);
    step(1, 2'b00, 0);

    // Hold with enb low while modo and D toggle.
    step(1, 2'b11, 16'h0ABC);
    for (int i = 0; i < 10; i++) begin
      step(0, 2'($urandom_range(0, 3)), int'($urandom_range(0, 65535)));
    end

    // Randomised operations, biased towards values near the bounds.
    for (int i = 0; i < 400; i++) begin
      dsel = $urandom_range(0, 3);
      case (dsel)
        0: dv = $urandom_range(0, 4);
        1: dv = $urandom_range(65531, 65535);
        2: dv = $urandom_range(0, 255) << 8 | 8'hFE;
        default: dv = $urandom_range(0, 65535);
      endcase
      step($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), dv);
    end

    repeat (3) @(negedge clk);
    chk("queue_drain", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/contador_param.md
# contador_param

Parametrised synchronous up/down/step counter with parallel load, the next generation of the team's 16-bit cascaded counter. Width and slice size are generics; per-slice ripple-carry flags are registered and aligned with `Q`. An optional saturating mode and a sticky overflow flag are added. The block sits wherever the design needs a loadable event/timer counter, and it is driven directly by the standard `probador`-style benches.

## Interface

Parameters:
- `WIDTH`, 16: counter width in bits. Must be a multiple of `SLICE`.
- `SLICE`, 4: slice width for carry reporting. `NS = WIDTH/SLICE` slices.
- `STEP`, 3: decrement used in mode `2'b10`. Valid range is 1..2^SLICE-1.
- `SAT`, 0: 0 means the counter wraps modulo 2^WIDTH. 1 means it saturates at the bounds.

Ports:
- `clk`, input, 1: clock. All state updates on the rising edge.
- `reset_L`, input, 1: asynchronous, active-low reset.
- `enb`, input, 1: count/load enable.
- `modo`, input, 2: operation select.
- `D`, input, WIDTH: parallel load value.
- `Q`, output, WIDTH: counter value (registered).
- `RCO`, output, NS: per-slice ripple-carry/borrow flags (registered).
- `ovf`, output, 1: sticky full-width overflow/underflow flag (registered).

## Operation

- Reset: `reset_L`=0 forces `Q`=0, `RCO`=0 and `ovf`=0 immediately, independent of `clk`. This applies mid-operation too.
- `enb`=0: `Q` holds and `ovf` holds. `RCO` is 0. `modo` and `D` are ignored.
- `enb`=1, by `modo`:
  - `2'b00`: Q ← Q + 1.
  - `2'b01`: Q ← Q − 1.
  - `2'b10`: Q ← Q − STEP.
  - `2'b11`: Q ← D. `RCO` is 0 and `ovf` is cleared.
  - Any X/Z on `modo` while `enb`=1: treat as hold, with `RCO`=0.
- Arithmetic is performed at WIDTH+1 bits. The full-width carry or borrow is bit WIDTH of the result.
- `RCO[i]` for i = 0..NS−1 is 1 in the cycle after an update iff that update produced a carry (up) or borrow (down) out of bits `[(i+1)*SLICE-1:0]`.
  - It is computed from the pre-update `Q` and the operand.
  - `RCO[NS-1]` equals the full-width carry/borrow.
  - `RCO` is a one-cycle pulse per update. It is not a level.
- Wrap mode (`SAT`=0):
  - The result is taken modulo 2^WIDTH.
  - A full-width carry/borrow sets `ovf`=1.
- Saturating mode (`SAT`=1):
  - If the update would produce a full-width carry, `Q` becomes all-ones.
  - If the update would produce a full-width borrow, `Q` becomes 0.
  - In either case `ovf` is set to 1 and all `RCO` bits are 0 for that cycle.
  - Non-overflowing updates behave exactly as in wrap mode, including `RCO`.
- `ovf` clears only on reset or a load (`modo`=`2'b11` with `enb`=1). A load and an overflow cannot coincide.

## Timing

- Latency is 1 cycle. `Q`, `RCO` and `ovf` reflect an operation after the rising edge at which `enb`/`modo`/`D` are sampled.
- `RCO` and `Q` change on the same edge, so no combinational path exists from inputs to outputs.
- Reset has priority over everything. Deassertion of `reset_L` is sampled at the next rising edge, and the first operation takes effect at that edge.
- Back-to-back operations are allowed every cycle, with no bubbles.
- With `SAT`=1 at a bound, repeated overflowing operations keep `Q` clamped, keep `ovf`=1 and keep `RCO`=0.

## Test plan

With `WIDTH`=16, `SLICE`=4, `STEP`=3, and `SAT`=0 unless noted:

1. Reset mid-count: count up from 0x0010 and drop `reset_L` between edges. Required: `Q`=0x0000, `RCO`=4'b0000 and `ovf`=0 immediately, without waiting for an edge. After release, the first up-count gives `Q`=0x0001.
2. Load 0x00FF, then `modo`=00 for one cycle. Required: `Q`=0x0100 and `RCO`=4'b0011, then `RCO`=4'b0000 on the next count (`Q`=0x0101).
3. Load 0xFFFF, then `modo`=00. Required: `Q`=0x0000, `RCO`=4'b1111 and `ovf`=1. `ovf` stays 1 through further counts until a load of 0x1234 clears it.
4. Load 0x0002, then `modo`=10. Required: `Q`=0xFFFF, `RCO`=4'b1111 and `ovf`=1. Next `modo`=01 gives `Q`=0xFFFE and `RCO`=4'b0000.
5. `SAT`=1: load 0x0001, then `modo`=10 for two cycles. Required: `Q`=0x0000, `ovf`=1 and `RCO`=4'b0000 on both cycles. Then load 0xFFFE and `modo`=00 twice. Required: `Q`=0xFFFF with `RCO`=4'b0000 and `ovf`=0, then `Q`=0xFFFF with `ovf`=1.
6. Hold: at `Q`=0x0ABC, set `enb`=0 and toggle `modo` and `D` for 10 cycles. Required: `Q` stays 0x0ABC, `RCO`=0 and `ovf` is unchanged throughout.
